vga_char_update_scheduler: RTL and testbench

- Sits between the processor/keyboard and the VGA character overlay.
- Owns the display_char / x_pos / y_pos registers that drive the sprite-lookup datapath.
- Arbitrates two requesters (processor memory-mapped writes, PS/2 keyboard bytes) into a small update FIFO.
- Applies at most one queued update per video frame, only at frame end, so the overlay never tears mid-frame.

---
 rtl/vga_char_update_scheduler.sv | 231 +++++++++++++++++++++++
 tb/tb_vga_char_update_scheduler.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_char_update_scheduler.sv
// Frame-synchronous update scheduler for the VGA character overlay: queues processor and
// keyboard updates and commits at most one per frame end. Optional macro: VGA_SCHED_AUTOADV_EN.
module vga_char_update_scheduler #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h2000,
  parameter int unsigned CHAR_W     = 50,
  parameter int unsigned CHAR_H     = 50,
  parameter int unsigned RESET_X    = 150,
  parameter int unsigned RESET_Y    = 150
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_end,
  input  logic [31:0] proc_addr,
  input  logic [31:0] proc_data,
  input  logic        proc_we,
  input  logic [7:0]  kb_data,
  input  logic        kb_valid,
  output logic [7:0]  display_char,
  output logic [9:0]  x_pos,
  output logic [8:0]  y_pos,
  output logic        commit_pulse,
  output logic        pending,
  output logic        fifo_full,
  output logic [7:0]  drop_count
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = 27;

  localparam logic [7:0] RstChar = 8'h20;
  localparam logic [9:0] RstX    = 10'(RESET_X);
  localparam logic [8:0] RstY    = 9'(RESET_Y);

  typedef enum logic [1:0] {StIdle, StLoad, StCommit} state_e;

  state_e          state_q, state_d;
  logic            fe_q;
  logic [7:0]      stg_char_q, stg_char_d;
  logic [9:0]      stg_x_q, stg_x_d;
  logic [8:0]      stg_y_q, stg_y_d;
  logic            skid_valid_q, skid_valid_d;
  logic [EW-1:0]   skid_q, skid_d;
  logic [EW-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic [EW-1:0]   head_q;
  logic [7:0]      char_q;
  logic [9:0]      x_q;
  logic [8:0]      y_q;
  logic            commit_q;
  logic [7:0]      drop_q, drop_d;

  logic            wr_char, wr_x, wr_y, proc_push;
  logic [EW-1:0]   proc_entry, kb_entry, push_entry;
  logic            push_req, push_ok, fifo_drop, kb_drop, kb_accept, kb_direct, kb_adv;
  logic            full, pop, load_head, fe_edge;
  logic [9:0]      adv_x;
  logic [8:0]      adv_y;
  logic [8:0]      drop_sum;
  logic            unused_data;

  assign unused_data = ^proc_data[31:10];

  assign wr_char   = proc_we && (proc_addr == BASE_ADDR);
  assign wr_x      = proc_we && (proc_addr == BASE_ADDR + 32'd4);
  assign wr_y      = proc_we && (proc_addr == BASE_ADDR + 32'd8);
  assign proc_push = proc_we && (proc_addr == BASE_ADDR + 32'd12);

  // Both entries use the staging values from before any same-clock staging write.
  assign proc_entry = {stg_char_q, stg_x_q, stg_y_q};
  assign kb_entry   = {kb_data, stg_x_q, stg_y_q};

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign fe_edge = frame_end & ~fe_q;

  // Arbitration: processor push first, then a parked keyboard byte, then a fresh one.
  always_comb begin
    push_req     = 1'b0;
    push_entry   = '0;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    kb_drop      = 1'b0;
    kb_accept    = 1'b0;
    kb_direct    = 1'b0;
    if (proc_push) begin
      push_req   = 1'b1;
      push_entry = proc_entry;
    end else if (skid_valid_q) begin
      push_req     = 1'b1;
      push_entry   = skid_q;
      skid_valid_d = 1'b0;
    end
    if (kb_valid) begin
      if (skid_valid_q) begin
        kb_drop = 1'b1;
      end else if (proc_push) begin
        skid_valid_d = 1'b1;
        skid_d       = kb_entry;
        kb_accept    = 1'b1;
      end else begin
        push_req   = 1'b1;
        push_entry = kb_entry;
        kb_accept  = 1'b1;
        kb_direct  = 1'b1;
      end
    end
  end

  assign fifo_drop = push_req && full && !pop;
  assign push_ok   = push_req && !fifo_drop;
  assign kb_adv    = kb_accept && !(kb_direct && fifo_drop);

`ifdef VGA_SCHED_AUTOADV_EN
  logic [10:0] x_sum;
  logic [9:0]  y_sum;

  assign x_sum = {1'b0, stg_x_q} + 11'(CHAR_W);
  assign y_sum = {1'b0, stg_y_q} + 10'(CHAR_H);

  // Cursor advance: wrap to the next row when the following sprite would not fit.
  always_comb begin
    adv_x = stg_x_q;
    adv_y = stg_y_q;
    if (kb_adv) begin
      if (x_sum + 11'(CHAR_W) > 11'd640) begin
        adv_x = '0;
        adv_y = (y_sum > 10'd480) ? '0 : y_sum[8:0];
      end else begin
        adv_x = x_sum[9:0];
      end
    end
  end
`else
  logic unused_kb_adv;

  assign unused_kb_adv = kb_adv;
  assign adv_x         = stg_x_q;
  assign adv_y         = stg_y_q;
`endif

  assign stg_char_d = wr_char ? proc_data[7:0] : stg_char_q;
  assign stg_x_d    = wr_x    ? proc_data[9:0] : adv_x;
  assign stg_y_d    = wr_y    ? proc_data[8:0] : adv_y;

  assign drop_sum = {1'b0, drop_q} + 9'({1'b0, fifo_drop} + {1'b0, kb_drop});
  assign drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    load_head = 1'b0;
    pop       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fe_edge && (count_q != '0)) state_d = StLoad;
      end
      StLoad: begin
        load_head = 1'b1;
        state_d   = StCommit;
      end
      StCommit: begin
        pop     = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      fe_q         <= 1'b0;
      stg_char_q   <= RstChar;
      stg_x_q      <= RstX;
      stg_y_q      <= RstY;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_q       <= '0;
      char_q       <= RstChar;
      x_q          <= RstX;
      y_q          <= RstY;
      commit_q     <= 1'b0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      fe_q         <= frame_end;
      stg_char_q   <= stg_char_d;
      stg_x_q      <= stg_x_d;
      stg_y_q      <= stg_y_d;
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
      count_q      <= count_d;
      drop_q       <= drop_d;
      commit_q     <= pop;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        char_q   <= head_q[26:19];
        x_q      <= head_q[18:9];
        y_q      <= head_q[8:0];
      end
      if (load_head) head_q <= mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_entry;
  end

  assign display_char = char_q;
  assign x_pos        = x_q;
  assign y_pos        = y_q;
  assign commit_pulse = commit_q;
  assign pending      = (count_q != '0);
  assign fifo_full    = full;
  assign drop_count   = drop_q;

endmodule

// File: tb/tb_vga_char_update_scheduler.sv
// Self-checking bench for vga_char_update_scheduler: directed scenarios plus random traffic,
// every clock compared against a queue-based reference model.
module tb_vga_char_update_scheduler;

  localparam int DEPTH = 4;
  localparam int CW_PX = 50;
  localparam int CH_PX = 50;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_end;
  logic [31:0] proc_addr;
  logic [31:0] proc_data;
  logic        proc_we;
  logic [7:0]  kb_data;
  logic        kb_valid;
  logic [7:0]  display_char;
  logic [9:0]  x_pos;
  logic [8:0]  y_pos;
  logic        commit_pulse;
  logic        pending;
  logic        fifo_full;
  logic [7:0]  drop_count;

  always #5 clk = ~clk;

  vga_char_update_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .frame_end    (frame_end),
    .proc_addr    (proc_addr),
    .proc_data    (proc_data),
    .proc_we      (proc_we),
    .kb_data      (kb_data),
    .kb_valid     (kb_valid),
    .display_char (display_char),
    .x_pos        (x_pos),
    .y_pos        (y_pos),
    .commit_pulse (commit_pulse),
    .pending      (pending),
    .fifo_full    (fifo_full),
    .drop_count   (drop_count)
  );

  // Reference model state
  logic [26:0] q[$];
  int          s_char, s_x, s_y;
  int          m_char, m_x, m_y, m_commit, m_drops;
  bit          skid_v;
  logic [26:0] skid_e;
  bit          fe_prev;
  int          wait_clks;  // clocks until the scheduled commit; 0 = none scheduled

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    s_char = 8'h20; s_x = 150; s_y = 150;
    m_char = 8'h20; m_x = 150; m_y = 150;
    m_commit = 0; m_drops = 0;
    skid_v = 0; skid_e = '0; fe_prev = 0; wait_clks = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    int          q_before, drops;
    bit          pp, wc, wx, wy, have_push, kb_acc, kb_direct, committing, sv0;
    logic [26:0] pu, head, pe, ke;
    int          nx, ny;
    if (reset) begin
      model_reset();
      return;
    end
    q_before = q.size();
    drops = 0; have_push = 0; kb_acc = 0; kb_direct = 0; pu = '0;
    pp = proc_we && proc_addr == 32'h200C;
    wc = proc_we && proc_addr == 32'h2000;
    wx = proc_we && proc_addr == 32'h2004;
    wy = proc_we && proc_addr == 32'h2008;
    pe = {8'(s_char), 10'(s_x), 9'(s_y)};
    ke = {kb_data, 10'(s_x), 9'(s_y)};
    sv0 = skid_v;
    committing = (wait_clks == 1);
    if (pp) begin
      have_push = 1; pu = pe;
    end else if (sv0) begin
      have_push = 1; pu = skid_e; skid_v = 0;
    end
    if (kb_valid) begin
      if (sv0) drops++;
      else if (pp) begin
        skid_v = 1; skid_e = ke; kb_acc = 1;
      end else begin
        have_push = 1; pu = ke; kb_acc = 1; kb_direct = 1;
      end
    end
    m_commit = 0;
    if (committing) begin
      head = q.pop_front();
      m_char = int'(head[26:19]); m_x = int'(head[18:9]); m_y = int'(head[8:0]);
      m_commit = 1;
    end
    if (have_push) begin
      if (q_before == DEPTH && !committing) begin
        drops++;
        if (kb_direct) kb_acc = 0;
      end else q.push_back(pu);
    end
    if (wait_clks > 0) wait_clks--;
    else if (frame_end && !fe_prev && q_before > 0) wait_clks = 2;
    fe_prev = frame_end;
    m_drops = (m_drops + drops > 255) ? 255 : m_drops + drops;
    nx = s_x; ny = s_y;
`ifdef VGA_SCHED_AUTOADV_EN
    if (kb_acc) begin
      nx = s_x + CW_PX;
      if (nx + CW_PX > 640) begin
        nx = 0;
        ny = s_y + CH_PX;
        if (ny > 480) ny = 0;
      end
    end
`endif
    if (wc) s_char = int'(proc_data[7:0]);
    s_x = wx ? int'(proc_data[9:0]) : nx;
    s_y = wy ? int'(proc_data[8:0]) : ny;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    vectors++;
    chk("display_char", 32'(display_char), 32'(m_char));
    chk("x_pos", 32'(x_pos), 32'(m_x));
    chk("y_pos", 32'(y_pos), 32'(m_y));
    chk("commit_pulse", 32'(commit_pulse), 32'(m_commit));
    chk("pending", 32'(pending), 32'(q.size() > 0));
    chk("fifo_full", 32'(fifo_full), 32'(q.size() == DEPTH));
    chk("drop_count", 32'(drop_count), 32'(m_drops));
  endtask

  task automatic idle_inputs();
    proc_we = 0; proc_addr = '0; proc_data = '0; kb_valid = 0; kb_data = '0;
  endtask

  task automatic pwrite(input logic [31:0] addr, input logic [31:0] data);
    proc_we = 1; proc_addr = addr; proc_data = data;
    tick();
    idle_inputs();
  endtask

  task automatic frame();
    frame_end = 1;
    repeat (4) tick();
    frame_end = 0;
    repeat (4) tick();
  endtask

  initial begin
    int fe_cnt;
    int idx;
    reset = 1; frame_end = 0;
    idle_inputs();
    model_reset();

    // Reset and idle frames: nothing committed
    repeat (3) tick();
    reset = 0;
    tick();
    frame();
    frame();
    chk("t1_char", 32'(display_char), 32'h20);
    chk("t1_x", 32'(x_pos), 32'd150);

    // Single update, exact two-clock latency after the edge clock
    pwrite(32'h2000, 32'h41);
    pwrite(32'h2004, 32'd200);
    pwrite(32'h2008, 32'd100);
    pwrite(32'h200C, 32'h0);
    frame_end = 1;
    tick();
    chk("t2_pulse_e0", 32'(commit_pulse), 32'd0);
    tick();
    chk("t2_pulse_e1", 32'(commit_pulse), 32'd0);
    tick();
    chk("t2_pulse_e2", 32'(commit_pulse), 32'd1);
    chk("t2_char", 32'(display_char), 32'h41);
    chk("t2_xy", {x_pos, 13'd0, y_pos}, {10'd200, 13'd0, 9'd100});
    chk("t2_pending", 32'(pending), 32'd0);
    tick();
    chk("t2_pulse_after", 32'(commit_pulse), 32'd0);
    frame_end = 0;
    repeat (4) tick();

    // Three entries, one per frame, FIFO order; fourth frame commits nothing
    for (int i = 0; i < 3; i++) begin
      pwrite(32'h2000, 32'h61 + i);
      pwrite(32'h200C, 32'h0);
    end
    for (int i = 0; i < 3; i++) begin
      frame();
      chk("t3_order", 32'(display_char), 32'h61 + i);
    end
    frame();
    chk("t3_no_commit", 32'(display_char), 32'h63);

    // Same-clock processor and keyboard push, then keyboard into an occupied skid
    proc_we = 1; proc_addr = 32'h200C; kb_valid = 1; kb_data = 8'h5A;
    tick();
    proc_we = 0; kb_data = 8'h33;
    tick();
    idle_inputs();
    tick();
    chk("t4_drop", 32'(drop_count), 32'd1);
    frame();
    chk("t4_first", 32'(display_char), 32'h63);
    frame();
    chk("t4_second", 32'(display_char), 32'h5A);

    // Full FIFO drop, then a push in the commit clock is accepted
    for (int i = 0; i < 5; i++) pwrite(32'h200C, 32'h0);
    chk("t5_full", 32'(fifo_full), 32'd1);
    chk("t5_drop", 32'(drop_count), 32'd2);
    frame_end = 1;
    tick();
    tick();
    proc_we = 1; proc_addr = 32'h200C;
    tick();
    idle_inputs();
    chk("t5_commit_push", {31'd0, commit_pulse}, 32'd1);
    chk("t5_still_full", 32'(fifo_full), 32'd1);
    chk("t5_drop_kept", 32'(drop_count), 32'd2);
    frame_end = 0;
    repeat (4) tick();
    repeat (5) frame();
    chk("t5_drained", 32'(pending), 32'd0);

    // Keyboard entries and cursor advance
    pwrite(32'h2004, 32'd550);
    pwrite(32'h2008, 32'd400);
    kb_valid = 1; kb_data = 8'h61;
    tick();
    idle_inputs();
    tick();
    kb_valid = 1; kb_data = 8'h62;
    tick();
    idle_inputs();
    pwrite(32'h200C, 32'h0);
    frame();
    chk("t6_e1", {x_pos, 13'd0, y_pos}, {10'd550, 13'd0, 9'd400});
    frame();
`ifdef VGA_SCHED_AUTOADV_EN
    chk("t6_e2", {x_pos, 13'd0, y_pos}, {10'd0, 13'd0, 9'd450});
    frame();
    chk("t6_stage", {x_pos, 13'd0, y_pos}, {10'd50, 13'd0, 9'd450});
`else
    chk("t6_e2", {x_pos, 13'd0, y_pos}, {10'd550, 13'd0, 9'd400});
    frame();
    chk("t6_stage", {x_pos, 13'd0, y_pos}, {10'd550, 13'd0, 9'd400});
`endif

    // Reset mid-operation discards queued and in-flight updates
    pwrite(32'h2000, 32'h77);
    pwrite(32'h200C, 32'h0);
    pwrite(32'h200C, 32'h0);
    frame_end = 1;
    tick();
    tick();
    reset = 1;
    tick();
    reset = 0;
    frame_end = 0;
    tick();
    frame();
    chk("t7_char", 32'(display_char), 32'h20);
    chk("t7_pending", 32'(pending), 32'd0);

    // drop_count saturation with a full FIFO and a stream of keyboard bytes
    for (int i = 0; i < DEPTH; i++) pwrite(32'h200C, 32'h0);
    kb_valid = 1;
    for (int i = 0; i < 300; i++) begin
      kb_data = 8'($urandom);
      tick();
    end
    idle_inputs();
    chk("t8_sat", 32'(drop_count), 32'hFF);
    reset = 1;
    tick();
    reset = 0;

    // Random traffic
    fe_cnt = 0;
    for (int i = 0; i < 4000; i++) begin
      idle_inputs();
      if ($urandom_range(0, 3) == 0) begin
        idx = $urandom_range(0, 5);
        proc_we = 1;
        proc_addr = (idx == 5) ? $urandom : 32'h2000 + 32'(idx * 4);
        proc_data = $urandom;
      end
      if ($urandom_range(0, 4) == 0) begin
        kb_valid = 1;
        kb_data = 8'($urandom);
      end
      if (fe_cnt == 0) begin
        frame_end = ~frame_end;
        fe_cnt = $urandom_range(2, 20);
      end else fe_cnt--;
      tick();
    end
    idle_inputs();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
